// File: rtl/nco_phase_gen_pkg.sv
// Shared definitions for the NCO phase generator and the sine-LUT it drives:
// FSM state encodings and default datapath widths.
package nco_phase_gen_pkg;

  localparam int DEFAULT_PHASE_WIDTH = 24;
  localparam int DEFAULT_ADDR_WIDTH  = 10;
  localparam int DEFAULT_LEN_WIDTH   = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/nco_phase_gen_phase_acc.sv
// Registered modular phase accumulator with parallel load; exposes only the
// top OUT_WIDTH bits, which is all the LUT address path needs.
module phase_acc #(
  parameter int PHASE_WIDTH = 24,
  parameter int OUT_WIDTH   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [PHASE_WIDTH-1:0] load_val,
  input  logic                   en,
  input  logic [PHASE_WIDTH-1:0] inc,
  output logic [OUT_WIDTH-1:0]   phase_msb
);

  logic [PHASE_WIDTH-1:0] acc_reg;

  // Overflow of the add is the intended modular wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (load) begin
      acc_reg <= load_val;
    end else if (en) begin
      acc_reg <= acc_reg + inc;
    end
  end

  assign phase_msb = acc_reg[PHASE_WIDTH-1 -: OUT_WIDTH];

endmodule

// File: rtl/nco_phase_gen.sv
// Pulsed NCO: emits pulse_len consecutive sine-LUT read addresses taken from a
// phase accumulator, with phase-continuous tuning word updates and abort.
module nco_phase_gen
  import nco_phase_gen_pkg::*;
#(
  parameter int PHASE_WIDTH = DEFAULT_PHASE_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int LEN_WIDTH   = DEFAULT_LEN_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [PHASE_WIDTH-1:0] cfg_ftw,
  input  logic [PHASE_WIDTH-1:0] cfg_poff,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   pulse_len,
  input  logic                   abort,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic                   rd_valid,
  output logic                   busy,
  output logic                   done
);

  state_t                 state_reg, state_next;
  logic [PHASE_WIDTH-1:0] ftw_reg;
  logic [PHASE_WIDTH-1:0] ftw_eff;
  logic [LEN_WIDTH-1:0]   cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0]  rd_addr_reg, rd_addr_next;
  logic                   rd_valid_reg, rd_valid_next;
  logic                   done_reg, done_next;
  logic                   done_pend_reg, done_pend_next;
  logic                   acc_load, acc_en;
  logic [ADDR_WIDTH-1:0]  acc_msb;

  // A write in the same cycle as an accumulation takes effect immediately,
  // so the frequency change lands on the very next phase step.
  assign ftw_eff = cfg_we ? cfg_ftw : ftw_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ftw_reg <= '0;
    end else if (cfg_we) begin
      ftw_reg <= cfg_ftw;
    end
  end

  phase_acc #(
    .PHASE_WIDTH(PHASE_WIDTH),
    .OUT_WIDTH  (ADDR_WIDTH)
  ) u_phase_acc (
    .clk      (clk),
    .rst      (rst),
    .load     (acc_load),
    .load_val (cfg_poff),
    .en       (acc_en),
    .inc      (ftw_eff),
    .phase_msb(acc_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      rd_addr_reg   <= '0;
      rd_valid_reg  <= 1'b0;
      done_reg      <= 1'b0;
      done_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rd_addr_reg   <= rd_addr_next;
      rd_valid_reg  <= rd_valid_next;
      done_reg      <= done_next;
      done_pend_reg <= done_pend_next;
    end
  end

  // done is delayed one cycle behind the last sample so it lines up with the
  // first cycle where rd_valid has dropped.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    rd_addr_next   = rd_addr_reg;
    rd_valid_next  = 1'b0;
    done_next      = done_pend_reg;
    done_pend_next = 1'b0;
    acc_load       = 1'b0;
    acc_en         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (pulse_len != '0) begin
            acc_load   = 1'b1;
            cnt_next   = pulse_len;
            state_next = ST_RUN;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else begin
          rd_addr_next  = acc_msb;
          rd_valid_next = 1'b1;
          acc_en        = 1'b1;
          cnt_next      = cnt_reg - LEN_WIDTH'(1);
          if (cnt_reg == LEN_WIDTH'(1)) begin
            state_next     = ST_IDLE;
            done_pend_next = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rd_addr  = rd_addr_reg;
  assign rd_valid = rd_valid_reg;
  assign busy     = (state_reg == ST_RUN);
  assign done     = done_reg;

endmodule

// File: tb/tb_nco_phase_gen.sv
// Self-checking bench for nco_phase_gen: per-cycle comparison against a
// pulse-level reference model, plus directed literal sequences.
module tb_nco_phase_gen;

  localparam int PW = 24;
  localparam int AW = 10;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [PW-1:0] cfg_ftw = '0;
  logic [PW-1:0] cfg_poff = '0;
  logic          start = 1'b0;
  logic [LW-1:0] pulse_len = '0;
  logic          abort = 1'b0;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  nco_phase_gen dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_ftw  (cfg_ftw),
    .cfg_poff (cfg_poff),
    .start    (start),
    .pulse_len(pulse_len),
    .abort    (abort),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a pulse is "samples left" plus a running phase value.
  logic [PW-1:0] m_phase = '0;
  logic [PW-1:0] m_ftw = '0;
  int            m_left = 0;
  bit            m_done_due = 0;
  logic [AW-1:0] exp_addr = '0;
  bit            exp_valid = 0;
  bit            exp_done = 0;
  bit            exp_busy = 0;

  always @(posedge clk) begin
    logic [PW-1:0] step;
    if (rst) begin
      m_phase = '0; m_ftw = '0; m_left = 0; m_done_due = 0;
      exp_addr = '0; exp_valid = 0; exp_done = 0;
    end else begin
      step = cfg_we ? cfg_ftw : m_ftw;
      exp_done = m_done_due;
      m_done_due = 0;
      exp_valid = 0;
      if (m_left > 0) begin
        if (abort) begin
          m_left = 0;
        end else begin
          exp_valid = 1;
          exp_addr  = AW'(m_phase / (1 << (PW - AW)));
          m_phase   = PW'((longint'(m_phase) + longint'(step)) % (64'd1 << PW));
          m_left    = m_left - 1;
          if (m_left == 0) m_done_due = 1;
        end
      end else if (start) begin
        if (pulse_len == 0) exp_done = 1;
        else begin
          m_phase = cfg_poff;
          m_left  = int'(pulse_len);
        end
      end
      if (cfg_we) m_ftw = cfg_ftw;
    end
    exp_busy = (m_left > 0);
  end

  // Observation of the DUT: every-cycle compare plus capture for directed tests.
  int cap[$];
  int done_cnt = 0;
  bit busy_seen = 0;

  always @(posedge clk) begin
    #1;
    check("rd_valid", rd_valid, exp_valid);
    check("rd_addr", rd_addr, exp_addr);
    check("busy", busy, exp_busy);
    check("done", done, exp_done);
    if (rd_valid) cap.push_back(int'(rd_addr));
    if (done) done_cnt++;
    if (busy) busy_seen = 1;
  end

  task automatic clear_obs();
    @(negedge clk);
    cap.delete();
    done_cnt = 0;
    busy_seen = 0;
  endtask

  task automatic pulse_start(input bit we, input logic [PW-1:0] ftw,
                             input logic [PW-1:0] poff, input int len);
    @(negedge clk);
    cfg_we = we; cfg_ftw = ftw; cfg_poff = poff; pulse_len = LW'(len); start = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
  endtask

  task automatic wait_samples(input string name, input int n);
    for (int k = 0; k < 60 && cap.size() < n; k++) @(negedge clk);
    if (cap.size() < n) check({name, "_timeout"}, cap.size(), n);
  endtask

  task automatic expect_seq(input string name, input int exp_q[$], input int exp_done);
    check({name, "_count"}, cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check({name, "_addr"}, (i < cap.size()) ? cap[i] : -1, exp_q[i]);
    check({name, "_done"}, done_cnt, exp_done);
    $display("test %s: %0d samples, %0d done pulses", name, cap.size(), done_cnt);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_addr", rd_addr, 0);
    check("reset_valid", rd_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    // Basic pulse, 4 samples.
    clear_obs();
    pulse_start(1, 24'h040000, 24'h000000, 4);
    repeat (10) @(negedge clk);
    expect_seq("basic", '{0, 16, 32, 48}, 1);

    // Phase wrap-around.
    clear_obs();
    pulse_start(1, 24'h400000, 24'hC00000, 3);
    repeat (10) @(negedge clk);
    expect_seq("wrap", '{768, 0, 256}, 1);

    // Zero-length pulse.
    clear_obs();
    pulse_start(0, 24'h0, 24'h0, 0);
    repeat (5) @(negedge clk);
    expect_seq("zero_len", '{}, 1);
    check("zero_len_busy", busy_seen, 0);

    // Start while busy ignored, then abort after the 3rd sample.
    clear_obs();
    pulse_start(1, 24'h040000, 24'h000000, 8);
    wait_samples("abort_first", 1);
    start = 1'b1; cfg_poff = 24'h123456; pulse_len = LW'(2);
    @(negedge clk);
    start = 1'b0;
    wait_samples("abort_third", 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (12) @(negedge clk);
    expect_seq("abort", '{0, 16, 32}, 0);

    // Phase-continuous tuning change after the 2nd sample.
    clear_obs();
    pulse_start(1, 24'h040000, 24'h000000, 6);
    wait_samples("retune", 2);
    cfg_we = 1'b1; cfg_ftw = 24'h080000;
    @(negedge clk);
    cfg_we = 1'b0;
    repeat (10) @(negedge clk);
    expect_seq("retune", '{0, 16, 32, 64, 96, 128}, 1);

    // Reset mid-pulse together with abort, start and cfg_we.
    clear_obs();
    pulse_start(1, 24'h040000, 24'h100000, 10);
    wait_samples("rst_mid", 2);
    rst = 1'b1; abort = 1'b1; start = 1'b1; cfg_we = 1'b1; cfg_ftw = 24'h111111;
    @(posedge clk);
    #2;
    check("rst_mid_addr", rd_addr, 0);
    check("rst_mid_valid", rd_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    @(negedge clk);
    rst = 1'b0; abort = 1'b0; start = 1'b0; cfg_we = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_mid_no_done", done_cnt, 0);
    // Tuning word must have been cleared by reset despite cfg_we.
    clear_obs();
    pulse_start(0, 24'h0, 24'h800000, 3);
    repeat (8) @(negedge clk);
    expect_seq("ftw_after_rst", '{512, 512, 512}, 1);

    // Randomized traffic checked cycle-by-cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 7) == 0);
      pulse_len = LW'($urandom_range(0, 12));
      cfg_poff  = PW'($urandom);
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_ftw   = PW'($urandom);
      abort     = ($urandom_range(0, 29) == 0);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; cfg_we = 1'b0; abort = 1'b0;
    repeat (20) @(negedge clk);
    $display("random phase: 4000 cycles of mixed start/abort/cfg_we/rst traffic");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
